// File: rtl/idct_1d_8x1.sv
// ---------------------------------------------------------------------------
// idct_1d_8x1 -- time-multiplexed inverse 1-D 8-point DCT.
//
// Computes x[n] = sum_k C[k][n] * X[k]. C is the forward DCT matrix used
// transposed. One coefficient index k is processed per cycle using 8 parallel
// multipliers and 8 accumulators. The result is rounded half toward +inf,
// shifted down by FRAC_BITS and saturated to DATA_WIDTH.
//
// Ports
//   clk           sole clock, rising edge
//   reset         synchronous, active-high
//   in_valid      data_in carries a coefficient vector
//   in_ready      block can accept a vector (IDLE only)
//   data_in       X[k] at [k*DATA_WIDTH +: DATA_WIDTH]
//   coeff_vector  C[k][n] at [((7-k)*8+n)*DATA_WIDTH +: DATA_WIDTH]; must stay
//                 stable from the accept edge until out_valid rises
//   out_valid     data_out valid, held until out_ready
//   out_ready     downstream accepts data_out
//   data_out      x[n] at [n*DATA_WIDTH +: DATA_WIDTH], registered
// ---------------------------------------------------------------------------
module idct_1d_8x1 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH*8-1:0]  data_in,
  input  logic [DATA_WIDTH*64-1:0] coeff_vector,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH*8-1:0]  data_out
);

  localparam int unsigned ProdWidth = 2 * DATA_WIDTH;
  // Three guard bits absorb the growth of an 8-term sum.
  localparam int unsigned AccWidth  = 2 * DATA_WIDTH + 3;

  // Half an output LSB, added before the arithmetic shift.
  localparam logic signed [AccWidth-1:0] RoundConst =
    {{(AccWidth - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};
  // Signed DATA_WIDTH range expressed at accumulator width.
  localparam logic signed [AccWidth-1:0] MaxVal =
    {{(AccWidth - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [AccWidth-1:0] MinVal =
    {{(AccWidth - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  state_e                       state_q;
  logic [2:0]                   k_q;
  logic signed [DATA_WIDTH-1:0] x_q   [8];
  logic signed [AccWidth-1:0]   acc_q [8];
  logic [DATA_WIDTH*8-1:0]      data_out_q;
  logic                         out_valid_q;

  // Datapath for the current index k.
  logic signed [DATA_WIDTH-1:0] x_k;
  logic signed [DATA_WIDTH-1:0] coef_k  [8];
  logic signed [ProdWidth-1:0]  prod    [8];
  logic signed [AccWidth-1:0]   sum     [8];
  logic signed [AccWidth-1:0]   rounded [8];
  logic signed [AccWidth-1:0]   shifted [8];
  logic [DATA_WIDTH*8-1:0]      data_out_d;

  always_comb begin
    x_k        = x_q[k_q];
    data_out_d = '0;
    for (int n = 0; n < 8; n++) begin
      // Row k of the forward matrix, indexed by n: the transposed product.
      coef_k[n]  = coeff_vector[((7 - int'(k_q)) * 8 + n) * DATA_WIDTH +: DATA_WIDTH];
      prod[n]    = ProdWidth'(coef_k[n]) * ProdWidth'(x_k);
      sum[n]     = acc_q[n] + AccWidth'(prod[n]);
      rounded[n] = sum[n] + RoundConst;
      shifted[n] = rounded[n] >>> FRAC_BITS;
      if (shifted[n] > MaxVal) begin
        data_out_d[n*DATA_WIDTH +: DATA_WIDTH] = MaxVal[DATA_WIDTH-1:0];
      end else if (shifted[n] < MinVal) begin
        data_out_d[n*DATA_WIDTH +: DATA_WIDTH] = MinVal[DATA_WIDTH-1:0];
      end else begin
        data_out_d[n*DATA_WIDTH +: DATA_WIDTH] = shifted[n][DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      for (int n = 0; n < 8; n++) begin
        x_q[n]   <= '0;
        acc_q[n] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            for (int n = 0; n < 8; n++) begin
              x_q[n]   <= data_in[n*DATA_WIDTH +: DATA_WIDTH];
              acc_q[n] <= '0;
            end
            k_q     <= '0;
            state_q <= StAccum;
          end
        end
        StAccum: begin
          for (int n = 0; n < 8; n++) begin
            acc_q[n] <= sum[n];
          end
          k_q <= k_q + 3'd1;
          if (k_q == 3'd7) begin
            // Last term is folded in combinationally so the result lands here.
            data_out_q  <= data_out_d;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

endmodule

// File: doc/idct_1d_8x1.md
# idct_1d_8x1

Inverse 1-D 8-point DCT. It takes one 8-coefficient vector from the DCT domain and returns 8 spatial-domain samples. It sits on the decode path opposite `dct_1d_8x1` and uses the same 64-entry forward coefficient matrix, applied transposed: x[n] = Σk C[k][n]·X[k]. It is time-multiplexed: 8 parallel multipliers, one coefficient index k per cycle, 8 accumulators, valid/ready handshake on both sides.

## Interface
Parameters:
- DATA_WIDTH, 32: width of every sample and coefficient; signed two's-complement fixed point.
- FRAC_BITS, 16: fractional bits of the coefficients; 1.0 = 1<<FRAC_BITS.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high; one clock, sampled on the clk rising edge.
- in_valid  in  1  data_in holds a valid coefficient vector.
- in_ready  out  1  block can accept; high only in IDLE.
- data_in  in  DATA_WIDTH*8  X[k] at [k*DATA_WIDTH +: DATA_WIDTH].
- coeff_vector  in  DATA_WIDTH*64  C[k][n] at [((7-k)*8+n)*DATA_WIDTH +: DATA_WIDTH]; identical layout to the forward DCT matrix.
- out_valid  out  1  data_out valid.
- out_ready  in  1  downstream accepts data_out.
- data_out  out  DATA_WIDTH*8  x[n] at [n*DATA_WIDTH +: DATA_WIDTH], registered.

## Operation
- The FSM has three states: IDLE, ACCUM, DONE.
  - IDLE: in_ready=1. On in_valid, the block captures data_in into x_reg, clears all 8 accumulators, sets k=0 and goes to ACCUM.
  - ACCUM: each cycle, acc[n] += C[k][n]·X[k] for all n in parallel, then k increments. When k=7 the block computes the final sum, registers the rounded result into data_out, sets out_valid and goes to DONE.
  - DONE: out_valid=1 and data_out is held stable. On out_ready the block clears out_valid and returns to IDLE. data_out keeps its last value.
- in_ready is 0 in ACCUM and DONE. An in_valid arriving then is ignored; the upstream must hold it until in_ready rises.
- coeff_vector is read live during ACCUM. It must stay stable from the accept edge until out_valid rises. data_in is needed only on the accept edge.
- Products are full 2·DATA_WIDTH signed. Accumulators are 2·DATA_WIDTH+3 bits and cannot overflow across 8 terms.
- Output conversion:
  - Add 1<<(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS (round half toward +∞).
  - Saturate to the signed DATA_WIDTH range: 0x7FFFFFFF / 0x80000000 at the default width.
- Reset in any state, including mid-ACCUM or DONE: go to IDLE, out_valid=0, data_out=0, accumulators=0, k=0. Any in-flight vector is discarded with no output.
- Reset values: in_ready=1 from the first cycle after reset, out_valid=0, data_out=0.

## Timing
- Accept edge E0 is the edge where in_valid && in_ready.
- Edges E1..E8 accumulate k=0..7. The result is registered at E8, and out_valid is visible in the cycle after E8.
- Latency is 8 clocks from accept to out_valid.
- Output handshake completes on the first edge with out_valid && out_ready, which returns the block to IDLE. The earliest next accept is the following edge.
- Minimum input-to-input spacing is 10 clocks when out_ready is held high.
- No combinational path from in_valid or out_ready to any output except through the state register.

## Test plan
- Identity: C[k][n]=0x00010000 when k=n, otherwise 0. X=[1,-2,3,-4,5,-6,7,-8] in Q16 -> data_out equals X exactly, and out_valid rises 8 clocks after accept.
- Transpose check: C[0][n]=0x00010000 for all n, all other entries 0. X[0]=0x00050000, all other X=0 -> every x[n]=0x00050000. With the matrix instead built as C[k][0]=1.0, only x[0] is nonzero.
- Rounding and saturation, with C[0][0]=0x8000 (0.5):
  - X[0]=1 -> x[0]=1; X[0]=-1 -> x[0]=0.
  - All C=0x00010000 and all X=0x7FFFFFFF -> all outputs 0x7FFFFFFF.
  - All X=0x80000000 -> all outputs 0x80000000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - out_valid and data_out stay stable, and in_ready stays 0 even with in_valid=1.
  - When out_ready rises, the block accepts the next vector 1 edge after the handshake.
- Reset mid-operation: assert reset at the 4th ACCUM cycle -> next cycle in_ready=1, out_valid=0, data_out=0. A fresh vector then produces the correct result with no stale accumulation.
- Round trip: run 8 random Q16 samples through the forward DCT with the orthonormal matrix, then through this block with the same coeff_vector -> each output within ±2 LSB of the original sample.
